// File: rtl/seg_time_reader_pkg.sv
// Shared definitions for the 7-segment time reader: segment patterns (active-low, bit6=g..bit0=a),
// decoded digit codes, day length and FSM states.
package seg_time_reader_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIGIT_BLANK = 4'd10;
    localparam logic [3:0] DIGIT_BAD   = 4'd15;

    localparam int unsigned SEC_PER_DAY = 86400;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_EVAL
    } state_t;

endpackage

// File: rtl/seg_time_reader_decode.sv
// Combinational 7-segment pattern to digit decoder; unlit display yields DIGIT_BLANK,
// anything unrecognised yields DIGIT_BAD.
module seg7_decode
    import seg_time_reader_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit
);

    always_comb begin
        digit = DIGIT_BAD;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: digit = DIGIT_BLANK;
            default:   digit = DIGIT_BAD;
        endcase
    end

endmodule

// File: rtl/seg_time_reader.sv
// Reconstructs HH:MM:SS from the six display digit buses once they have been stable,
// range-checks the frame and optionally verifies one-second advancement between readings.
module seg_time_reader
    import seg_time_reader_pkg::*;
#(
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned SEC_PER_DAY = seg_time_reader_pkg::SEC_PER_DAY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg1h,
    input  logic [6:0]  seg0h,
    input  logic [6:0]  seg1m,
    input  logic [6:0]  seg0m,
    input  logic [6:0]  seg1s,
    input  logic [6:0]  seg0s,
    input  logic        check_en,
    output logic        time_valid,
    output logic [4:0]  hour,
    output logic [5:0]  minute,
    output logic [5:0]  second,
    output logic [16:0] total,
    output logic [5:0]  blank_mask,
    output logic        frame_blank,
    output logic        frame_err,
    output logic        step_err
);

    localparam int unsigned CW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYC - 1);
    localparam logic [16:0]    DAY_LAST = 17'(SEC_PER_DAY - 1);

    logic [41:0]   seg_bus;
    logic [41:0]   in_q;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          have_prev;
    logic [16:0]   prev;
    logic          check_en_q;

    logic [3:0]    dig [6];
    logic [5:0]    blank_vec;
    logic          any_bad;
    logic          range_err;
    logic [6:0]    hour_v;
    logic [6:0]    min_v;
    logic [6:0]    sec_v;
    logic [16:0]   total_v;
    logic [16:0]   prev_next;
    logic          step_bad;

    assign seg_bus = {seg1h, seg0h, seg1m, seg0m, seg1s, seg0s};

    // Digit 0 is seg0s, digit 5 is seg1h, matching the blank_mask bit order.
    for (genvar i = 0; i < 6; i++) begin : g_dec
        seg7_decode u_dec (
            .seg   (in_q[7*i +: 7]),
            .digit (dig[i])
        );
    end

    always_comb begin
        any_bad   = 1'b0;
        blank_vec = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (dig[i] == DIGIT_BAD)   any_bad      = 1'b1;
            if (dig[i] == DIGIT_BLANK) blank_vec[i] = 1'b1;
        end
        hour_v    = 7'(dig[5]) * 7'd10 + 7'(dig[4]);
        min_v     = 7'(dig[3]) * 7'd10 + 7'(dig[2]);
        sec_v     = 7'(dig[1]) * 7'd10 + 7'(dig[0]);
        range_err = (hour_v > 7'd23) || (dig[3] > 4'd5) || (dig[1] > 4'd5);
        total_v   = 17'(hour_v) * 17'd3600 + 17'(min_v) * 17'd60 + 17'(sec_v);
        prev_next = (prev == DAY_LAST) ? '0 : prev + 17'd1;
        step_bad  = (total_v != prev) && (total_v != prev_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q        <= '1;
            state       <= ST_SETTLE;
            cnt         <= '0;
            have_prev   <= 1'b0;
            prev        <= '0;
            check_en_q  <= 1'b0;
            time_valid  <= 1'b0;
            hour        <= '0;
            minute      <= '0;
            second      <= '0;
            total       <= '0;
            blank_mask  <= '0;
            frame_blank <= 1'b0;
            frame_err   <= 1'b0;
            step_err    <= 1'b0;
        end else begin
            time_valid  <= 1'b0;
            frame_blank <= 1'b0;
            frame_err   <= 1'b0;
            step_err    <= 1'b0;
            check_en_q  <= check_en;
            if (check_en_q && !check_en) have_prev <= 1'b0;

            // An input change always wins, so a frame is only judged after a full quiet window.
            if (seg_bus != in_q) begin
                in_q  <= seg_bus;
                state <= ST_SETTLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_WAIT: ;
                    ST_SETTLE: begin
                        if (cnt == CNT_LAST) state <= ST_EVAL;
                        else                 cnt   <= cnt + CW'(1);
                    end
                    ST_EVAL: begin
                        state <= ST_WAIT;
                        if (any_bad) begin
                            frame_err <= 1'b1;
                        end else if (|blank_vec) begin
                            frame_blank <= 1'b1;
                            blank_mask  <= blank_vec;
                        end else if (range_err) begin
                            frame_err  <= 1'b1;
                            blank_mask <= '0;
                        end else begin
                            time_valid <= 1'b1;
                            blank_mask <= '0;
                            hour       <= hour_v[4:0];
                            minute     <= min_v[5:0];
                            second     <= sec_v[5:0];
                            total      <= total_v;
                            prev       <= total_v;
                            have_prev  <= 1'b1;
                            if (check_en && have_prev && step_bad) step_err <= 1'b1;
                        end
                    end
                    default: state <= ST_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_time_reader.sv
// Scoreboard bench for seg_time_reader: directed display frames push hand-computed events,
// a negedge monitor pops and compares whenever the reader emits a pulse.
module tb_seg_time_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg1h = 7'h7F, seg0h = 7'h7F, seg1m = 7'h7F, seg0m = 7'h7F, seg1s = 7'h7F, seg0s = 7'h7F;
    logic        check_en = 1'b0;
    logic        time_valid, frame_blank, frame_err, step_err;
    logic [4:0]  hour;
    logic [5:0]  minute, second, blank_mask;
    logic [16:0] total;

    seg_time_reader #(.STABLE_CYC(4), .SEC_PER_DAY(86400)) dut (
        .clk(clk), .rst_n(rst_n),
        .seg1h(seg1h), .seg0h(seg0h), .seg1m(seg1m), .seg0m(seg0m), .seg1s(seg1s), .seg0s(seg0s),
        .check_en(check_en), .time_valid(time_valid), .hour(hour), .minute(minute), .second(second),
        .total(total), .blank_mask(blank_mask), .frame_blank(frame_blank), .frame_err(frame_err),
        .step_err(step_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit tv, fb, fe, se;
        int h, m, s, tot;
        int mask;
        int due;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (time_valid || frame_blank || frame_err || step_err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: tv=%0b fb=%0b fe=%0b se=%0b, expected no pulse",
                         cyc, time_valid, frame_blank, frame_err, step_err);
            end else begin
                e = sb.pop_front();
                chk("time_valid",  int'(time_valid),  int'(e.tv));
                chk("frame_blank", int'(frame_blank), int'(e.fb));
                chk("frame_err",   int'(frame_err),   int'(e.fe));
                chk("step_err",    int'(step_err),    int'(e.se));
                chk("hour",        int'(hour),        e.h);
                chk("minute",      int'(minute),      e.m);
                chk("second",      int'(second),      e.s);
                chk("total",       int'(total),       e.tot);
                chk("blank_mask",  int'(blank_mask),  e.mask);
                if (e.due >= 0) chk("latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic expect_evt(input bit tv, input bit fb, input bit fe, input bit se,
                              input int h, input int m, input int s, input int tot,
                              input int mask, input int due);
        exp_t e;
        e.tv = tv; e.fb = fb; e.fe = fe; e.se = se;
        e.h = h; e.m = m; e.s = s; e.tot = tot; e.mask = mask; e.due = due;
        sb.push_back(e);
    endtask

    task automatic drive_raw(input logic [6:0] a5, input logic [6:0] a4, input logic [6:0] a3,
                             input logic [6:0] a2, input logic [6:0] a1, input logic [6:0] a0,
                             output int n);
        @(posedge clk);
        #1;
        seg1h = a5; seg0h = a4; seg1m = a3; seg0m = a2; seg1s = a1; seg0s = a0;
        n = cyc;
    endtask

    task automatic drive_time(input int h, input int m, input int s, output int n);
        drive_raw(seg_tab[h / 10], seg_tab[h % 10], seg_tab[m / 10], seg_tab[m % 10],
                  seg_tab[s / 10], seg_tab[s % 10], n);
    endtask

    task automatic check_zero_outputs();
        chk("rst_time_valid",  int'(time_valid),  0);
        chk("rst_frame_blank", int'(frame_blank), 0);
        chk("rst_frame_err",   int'(frame_err),   0);
        chk("rst_step_err",    int'(step_err),    0);
        chk("rst_hour",        int'(hour),        0);
        chk("rst_minute",      int'(minute),      0);
        chk("rst_second",      int'(second),      0);
        chk("rst_total",       int'(total),       0);
        chk("rst_blank_mask",  int'(blank_mask),  0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs();

        // Release with an all-blank display: first frame is judged even though it equals in_q's reset value.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = cyc;
        expect_evt(0, 1, 0, 0, 0, 0, 0, 0, 6'b111111, n + 5);
        repeat (10) @(posedge clk);

        drive_time(12, 34, 56, n);
        expect_evt(1, 0, 0, 0, 12, 34, 56, 45296, 0, n + 6);
        repeat (12) @(posedge clk);

        // Pulse check_en low after it was high so the 12:34:56 reading is forgotten.
        #1 check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_en = 1'b1;

        drive_time(23, 59, 59, n);
        expect_evt(1, 0, 0, 0, 23, 59, 59, 86399, 0, n + 6);
        repeat (10) @(posedge clk);
        drive_time(0, 0, 0, n);
        expect_evt(1, 0, 0, 0, 0, 0, 0, 0, 0, n + 6);
        repeat (10) @(posedge clk);
        drive_time(0, 0, 2, n);
        expect_evt(1, 0, 0, 1, 0, 0, 2, 2, 0, n + 6);
        repeat (10) @(posedge clk);

        // Short glitch on seg0s: the glitch itself is never judged; the restored frame is a legal repeat.
        drive_raw(seg_tab[0], seg_tab[0], seg_tab[0], seg_tab[0], seg_tab[0], seg_tab[3], n);
        repeat (2) @(posedge clk);
        drive_time(0, 0, 2, n);
        expect_evt(1, 0, 0, 0, 0, 0, 2, 2, 0, n + 6);
        repeat (10) @(posedge clk);

        drive_time(10, 20, 30, n);
        expect_evt(1, 0, 0, 1, 10, 20, 30, 37230, 0, n + 6);
        repeat (10) @(posedge clk);
        drive_raw(7'h7F, 7'h7F, seg_tab[2], seg_tab[0], seg_tab[3], seg_tab[0], n);
        expect_evt(0, 1, 0, 0, 10, 20, 30, 37230, 6'b110000, n + 6);
        repeat (10) @(posedge clk);
        drive_time(10, 20, 31, n);
        expect_evt(1, 0, 0, 0, 10, 20, 31, 37231, 0, n + 6);
        repeat (10) @(posedge clk);

        drive_raw(seg_tab[1], seg_tab[0], 7'h55, seg_tab[0], seg_tab[3], seg_tab[1], n);
        expect_evt(0, 0, 1, 0, 10, 20, 31, 37231, 0, n + 6);
        repeat (10) @(posedge clk);
        drive_time(24, 20, 31, n);
        expect_evt(0, 0, 1, 0, 10, 20, 31, 37231, 0, n + 6);
        repeat (10) @(posedge clk);

        // Reset while the new frame is still settling.
        drive_time(1, 2, 3, n);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_zero_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = cyc;
        expect_evt(1, 0, 0, 0, 1, 2, 3, 3723, 0, n + 6);
        repeat (12) @(posedge clk);

        chk("pending_events", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
